// File: rtl/frac_div_pkg.sv
// frac_div_pkg: shared types and constants for the fractional clock divider.
// Holds widths, reset config, FSM state enum, config struct and validity check.
package frac_div_pkg;

    localparam int unsigned DW = 5;
    localparam int unsigned NW = 8;

    localparam int unsigned DEF_DIV = 8;
    localparam int unsigned DEF_NLO = 3;
    localparam int unsigned DEF_NHI = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DW-1:0] div;
        logic [NW-1:0] n_lo;
        logic [NW-1:0] n_hi;
    } cfg_t;

    // D must leave room for D+1 in DW bits, and a frame needs a period.
    function automatic logic cfg_ok(cfg_t c);
        return (c.div >= DW'(2))
            && (c.div != '1)
            && ((c.n_lo | c.n_hi) != '0);
    endfunction

endpackage

// File: rtl/frac_div_sched_if.sv
// frac_div_sched_if: config valid/ready port of the fractional divider.
// master = config register block, slave = divider; cfg_err flags a bad config.
interface frac_div_sched_if;
    import frac_div_pkg::*;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_div;
    logic [NW-1:0] cfg_n_lo;
    logic [NW-1:0] cfg_n_hi;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_div, cfg_n_lo, cfg_n_hi,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_n_lo, cfg_n_hi,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/frac_div_period_gen.sv
// frac_div_period_gen: emits one clk_out period of length len per start strobe.
// Ports: start/len/hi in; clk_out, period_hi (registered), period_done (last cycle).
module frac_div_period_gen
    import frac_div_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] len,
    input  logic          hi,
    output logic          clk_out,
    output logic          period_hi,
    output logic          period_done
);

    logic [DW-1:0] ph_q, ph_d;
    logic [DW-1:0] len_q, len_d;
    logic          run_q, run_d;
    logic          clk_q, clk_d;
    logic          hi_q, hi_d;
    logic          last;

    always_comb begin
        last  = run_q && (ph_q == len_q - 1'b1);
        ph_d  = ph_q;
        len_d = len_q;
        run_d = run_q;
        clk_d = clk_q;
        hi_d  = hi_q;
        if (start) begin
            // A back-to-back start overrides the end of the previous period.
            ph_d  = '0;
            len_d = len;
            run_d = 1'b1;
            clk_d = (len >> 1) != '0;
            hi_d  = hi;
        end else if (last) begin
            ph_d  = '0;
            run_d = 1'b0;
            clk_d = 1'b0;
            hi_d  = 1'b0;
        end else if (run_q) begin
            ph_d  = ph_q + 1'b1;
            // High for the first floor(len/2) phases.
            clk_d = ph_d < (len_q >> 1);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            ph_q  <= '0;
            len_q <= '0;
            run_q <= 1'b0;
            clk_q <= 1'b0;
            hi_q  <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            len_q <= len_d;
            run_q <= run_d;
            clk_q <= clk_d;
            hi_q  <= hi_d;
        end
    end

    assign clk_out     = clk_q;
    assign period_hi   = hi_q;
    assign period_done = last;

endmodule

// File: rtl/frac_div_sched.sv
// frac_div_sched: fractional divider, frames of n_lo periods of D then n_hi of D+1.
// Ports: clk_in, rst (async low), en, cfg (slave), clk_out, period_hi, frame_start, busy.
module frac_div_sched #(
    parameter int unsigned DEF_DIV = frac_div_pkg::DEF_DIV,
    parameter int unsigned DEF_NLO = frac_div_pkg::DEF_NLO,
    parameter int unsigned DEF_NHI = frac_div_pkg::DEF_NHI
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    en,
    frac_div_sched_if.slave         cfg,
    output logic                    clk_out,
    output logic                    period_hi,
    output logic                    frame_start,
    output logic                    busy
);
    import frac_div_pkg::*;

    localparam cfg_t DEF_CFG = '{
        div:  DW'(DEF_DIV),
        n_lo: NW'(DEF_NLO),
        n_hi: NW'(DEF_NHI)
    };

    state_e        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    cfg_t          act_q, act_d;
    cfg_t          pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          err_q, err_d;
    logic          fs_q, fs_d;

    cfg_t          cfg_in;
    cfg_t          nxt;
    cfg_t          sel;
    logic          acc;
    logic          ok;
    logic          frm;
    logic          pstart;
    logic          phi;
    logic          pdone;
    logic [DW-1:0] plen;

    assign cfg_in = {cfg.cfg_div, cfg.cfg_n_lo, cfg.cfg_n_hi};
    assign acc    = cfg.cfg_valid && !pend_vld_q;
    assign ok     = cfg_ok(cfg_in);

    // Config for the next frame: a fresh one only counts while idle, so a
    // config taken on a busy boundary edge waits for the following boundary.
    assign nxt = (state_q == IDLE && acc && ok) ? cfg_in
               : pend_vld_q ? pend_q
               : act_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = acc && !ok;
        fs_d       = 1'b0;
        frm        = 1'b0;
        pstart     = 1'b0;
        phi        = 1'b0;

        unique case (state_q)
            IDLE: begin
                act_d      = nxt;
                pend_vld_d = 1'b0;
                frm        = en;
            end
            LO: if (pdone) begin
                if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q != act_q.n_lo - 1'b1) begin
                    cnt_d  = cnt_q + 1'b1;
                    pstart = 1'b1;
                end else if (act_q.n_hi != '0) begin
                    state_d = HI;
                    cnt_d   = '0;
                    pstart  = 1'b1;
                    phi     = 1'b1;
                end else begin
                    frm = 1'b1;
                end
            end
            HI: if (pdone) begin
                if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q != act_q.n_hi - 1'b1) begin
                    cnt_d  = cnt_q + 1'b1;
                    pstart = 1'b1;
                    phi    = 1'b1;
                end else begin
                    frm = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frm) begin
            act_d      = nxt;
            pend_vld_d = 1'b0;
            state_d    = (nxt.n_lo != '0) ? LO : HI;
            cnt_d      = '0;
            pstart     = 1'b1;
            phi        = (nxt.n_lo == '0);
            fs_d       = 1'b1;
        end

        if (acc && ok && state_q != IDLE) begin
            pend_d     = cfg_in;
            pend_vld_d = 1'b1;
        end

        sel  = frm ? nxt : act_q;
        plen = phi ? sel.div + 1'b1 : sel.div;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q      <= DEF_CFG;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            fs_q       <= fs_d;
        end
    end

    frac_div_period_gen u_pgen (
        .clk_in      (clk_in),
        .rst         (rst),
        .start       (pstart),
        .len         (plen),
        .hi          (phi),
        .clk_out     (clk_out),
        .period_hi   (period_hi),
        .period_done (pdone)
    );

    assign cfg.cfg_ready = !pend_vld_q;
    assign cfg.cfg_err   = err_q;
    assign frame_start   = fs_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/frac_div_sched.md
Name: frac_div_sched

Overview:
- Runtime-configurable fractional clock-divider controller.
- Produces an output clock whose average division ratio is M/N. Each frame is n_lo periods of length D input cycles, followed by n_hi periods of length D+1.
- Sequences the period mix per frame, keeps duty near 50% per period, and accepts new ratios through a valid/ready config port. New ratios are applied only at frame boundaries, so clk_out never glitches.
- Sits between the clock-config register block and the clocked consumer.

Parameters:
- DW, 5: width of divisor and period phase counter. D+1 must fit, so D ≤ 2^DW−2.
- NW, 8: width of the period-count fields n_lo and n_hi.
- DEF_DIV, 8: reset value of active D.
- DEF_NLO, 3: reset value of active n_lo.
- DEF_NHI, 7: reset value of active n_hi. With the defaults, a frame is 3×8 + 7×9 = 87 cycles containing 10 periods.

Ports:
- clk_in, in, 1: input clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: run request.
- cfg_valid, in, 1: config offer.
- cfg_ready, out, 1: config slot free.
- cfg_div, in, DW: new D.
- cfg_n_lo, in, NW: new count of D-length periods.
- cfg_n_hi, in, NW: new count of (D+1)-length periods.
- cfg_err, out, 1: one-cycle pulse when an accepted config is invalid.
- clk_out, out, 1: divided clock, registered.
- period_hi, out, 1: high throughout every clk_out period of length D+1.
- frame_start, out, 1: one-cycle pulse on the first cycle of each frame.
- busy, out, 1: state is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0, except cfg_ready = 1.
  - Active config = DEF_* values; pending slot empty; state IDLE.
- States: IDLE, LO, HI.
- Period shape, for a period of length P:
  - clk_out is high for the first floor(P/2) cycles and low for the remaining ceil(P/2).
  - Each period starts with a clk_out rising edge.
  - period_hi is registered together with clk_out.
- Starting from IDLE:
  - Trigger: en sampled 1 at edge t.
  - At edge t+1, enter LO if n_lo > 0, otherwise HI.
  - In cycle t+1, clk_out = 1 and frame_start = 1.
- LO:
  - Counts lo periods.
  - After period n_lo−1 completes: go to HI if n_hi > 0, otherwise take the frame boundary.
- HI:
  - After period n_hi−1 completes: take the frame boundary.
- Frame boundary actions:
  - If the pending slot is full, copy pending to active and free the slot.
  - If en = 1, start the next frame's first period in the very next cycle, with no gap cycle, and pulse frame_start.
  - If en = 0, go to IDLE.
- en deasserted mid-frame:
  - The current period completes, then the block goes to IDLE.
  - The frame position is discarded; the next start begins a fresh frame.
  - clk_out is 0 in IDLE.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready at an edge.
  - cfg_ready = 1 whenever the pending slot is empty.
  - Accepted in IDLE: applies directly to active in the same edge; the slot stays empty.
  - Accepted while busy: goes to the pending slot; cfg_ready drops until the next frame boundary.
  - A config that arrives while the pending slot is full is stalled, not overwritten.
- Config validity:
  - Invalid if cfg_div < 2, or cfg_div > 2^DW−2, or n_lo + n_hi = 0.
  - An invalid config is still accepted (handshake completes), then discarded. cfg_err pulses in the next cycle; active and pending are unchanged.
- Simultaneous events:
  - Config accepted on the same edge as a frame boundary with the slot empty: takes effect at the following boundary, not this one.
  - en rising and config accepted on the same edge in IDLE: the new config is used for the first frame.
- Arithmetic: period length = D or D+1, computed at DW bits with no overflow, guaranteed by the validity rule.
- Reset asserted mid-operation: immediate return to reset values, and the pending config is lost.

Decomposition:
- Package frac_div_pkg:
  - state enum (IDLE/LO/HI);
  - DW/NW localparams;
  - DEF_* constants;
  - config struct {div, n_lo, n_hi}.
- Sub-module frac_div_period_gen:
  - Inputs: period length, start strobe.
  - Contents: phase counter, clk_out/period_hi flops.
  - Output: period_done strobe on the last cycle of the period.
- The top module holds the FSM, the lo/hi period counters and the config shadow logic.

Test Plan:
- Reset release, en = 1 with defaults:
  - frame of exactly 87 cycles, 10 rising edges;
  - first 3 periods: 4 high / 4 low, period_hi = 0;
  - next 7 periods: 4 high / 5 low, period_hi = 1;
  - frame_start every 87 cycles.
- Config in IDLE D=2, n_lo=1, n_hi=1:
  - repeating 1H1L then 1H2L, period_hi = 1 only on the 3-cycle period;
  - frame_start every 5 cycles.
- While running defaults, send D=3, n_lo=0, n_hi=2:
  - cfg_ready goes 0 until the next boundary;
  - the first 87-cycle frame is unchanged;
  - afterwards, periods of 4 cycles (2H2L), period_hi = 1, frame of 8 cycles.
- Send cfg_div=1 (and separately n_lo = n_hi = 0):
  - cfg_err pulses once;
  - output waveform unchanged.
- Drop en in the middle of a 9-cycle period: the period finishes its 5 low cycles, then busy = 0 and clk_out stays 0.
- Assert rst mid-frame with a pending config: outputs return to reset values; after release and en = 1, the default 87-cycle frame runs.
